// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel alarm unit.
package alarm_pkg;

   typedef enum logic {
      ALM_ONESHOT  = 1'b0,
      ALM_PERIODIC = 1'b1
   } alarm_mode_e;

   // Channel index width, never narrower than one bit.
   function automatic int ch_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: programmed time/period/mode, match detection,
// periodic reload and sticky overrun tracking.
module alarm_channel
   import alarm_pkg::*;
#(
   parameter int TIME_W = 32
) (
   input  logic              clk,
   input  logic              i_arst,
   input  logic [TIME_W-1:0] i_clock_time,
   input  logic              i_wr,
   input  logic              i_wr_arm,
   input  alarm_mode_e       i_wr_mode,
   input  logic [TIME_W-1:0] i_wr_time,
   input  logic [TIME_W-1:0] i_wr_period,
   input  logic              i_ack,
   output logic              o_armed,
   output logic              o_pending,
   output logic              o_overrun,
   output logic              o_pending_nxt
);

   logic [TIME_W-1:0] time_q, time_d;
   logic [TIME_W-1:0] period_q, period_d;
   alarm_mode_e       mode_q, mode_d;
   logic              armed_q, armed_d;
   logic              pending_q, pending_d;
   logic              overrun_q, overrun_d;
   logic              match;

   always_comb begin
      time_d    = time_q;
      period_d  = period_q;
      mode_d    = mode_q;
      armed_d   = armed_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      match     = armed_q && (time_q == i_clock_time);

      // Write has priority over match, match over ack.
      if (i_wr) begin
         armed_d   = i_wr_arm;
         pending_d = 1'b0;
         overrun_d = 1'b0;
         if (i_wr_arm) begin
            time_d   = i_wr_time;
            period_d = i_wr_period;
            mode_d   = i_wr_mode;
         end
      end else if (match) begin
         pending_d = 1'b1;
         if (mode_q == ALM_PERIODIC && period_q != '0) begin
            time_d = time_q + period_q;
            if (pending_q && !i_ack) overrun_d = 1'b1;
         end else begin
            armed_d = 1'b0;
         end
      end else if (i_ack) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge i_arst) begin
      if (i_arst) begin
         time_q    <= '0;
         period_q  <= '0;
         mode_q    <= ALM_ONESHOT;
         armed_q   <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         time_q    <= time_d;
         period_q  <= period_d;
         mode_q    <= mode_d;
         armed_q   <= armed_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign o_armed       = armed_q;
   assign o_pending     = pending_q;
   assign o_overrun     = overrun_q;
   assign o_pending_nxt = pending_d;

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm unit: write/ack decode, per-channel alarms and a
// registered interrupt with lowest-index channel reporting.
module alarm_bank
   import alarm_pkg::*;
#(
   parameter  int TIME_W = 32,
   parameter  int N_CH   = 4,
   localparam int CH_W   = ch_width(N_CH)
) (
   input  logic              clk,
   input  logic              i_arst,
   input  logic [TIME_W-1:0] i_clock_time,
   input  logic              i_wr_en,
   input  logic [CH_W-1:0]   i_wr_ch,
   input  logic              i_wr_arm,
   input  logic              i_wr_mode,
   input  logic [TIME_W-1:0] i_wr_time,
   input  logic [TIME_W-1:0] i_wr_period,
   input  logic              i_ack,
   input  logic [CH_W-1:0]   i_ack_ch,
   output logic              o_int,
   output logic [CH_W-1:0]   o_int_ch,
   output logic [N_CH-1:0]   o_pending,
   output logic [N_CH-1:0]   o_armed,
   output logic [N_CH-1:0]   o_overrun
);

   logic [N_CH-1:0] pend_nxt;
   logic [CH_W-1:0] int_ch_nxt;

   // Out-of-range channel indices simply match no instance.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      alarm_channel #(.TIME_W(TIME_W)) u_ch (
         .clk           (clk),
         .i_arst        (i_arst),
         .i_clock_time  (i_clock_time),
         .i_wr          (i_wr_en && (i_wr_ch == CH_W'(i))),
         .i_wr_arm      (i_wr_arm),
         .i_wr_mode     (alarm_mode_e'(i_wr_mode)),
         .i_wr_time     (i_wr_time),
         .i_wr_period   (i_wr_period),
         .i_ack         (i_ack && (i_ack_ch == CH_W'(i))),
         .o_armed       (o_armed[i]),
         .o_pending     (o_pending[i]),
         .o_overrun     (o_overrun[i]),
         .o_pending_nxt (pend_nxt[i])
      );
   end

   always_comb begin
      int_ch_nxt = '0;
      for (int unsigned i = N_CH; i > 0; i--) begin
         if (pend_nxt[i-1]) int_ch_nxt = CH_W'(i - 1);
      end
   end

   always_ff @(posedge clk or posedge i_arst) begin
      if (i_arst) begin
         o_int    <= 1'b0;
         o_int_ch <= '0;
      end else begin
         o_int    <= |pend_nxt;
         o_int_ch <= int_ch_nxt;
      end
   end

endmodule

// File: tb/tb_alarm_bank.sv
// Bench for alarm_bank: directed vector table, reset sequence, and
// randomized traffic against a per-channel reference model.
module tb_alarm_bank;

   localparam int TW = 8;
   localparam int NC = 4;

   logic          clk = 1'b0;
   logic          i_arst;
   logic [TW-1:0] clk_time;
   logic          wr_en, wr_arm, wr_mode, ack;
   logic [1:0]    wr_ch, ack_ch;
   logic [TW-1:0] wr_time, wr_period;
   logic          o_int;
   logic [1:0]    o_int_ch;
   logic [NC-1:0] o_pending, o_armed, o_overrun;

   int n_pass  = 0;
   int n_total = 0;

   alarm_bank #(.TIME_W(TW), .N_CH(NC)) dut (
      .clk          (clk),
      .i_arst       (i_arst),
      .i_clock_time (clk_time),
      .i_wr_en      (wr_en),
      .i_wr_ch      (wr_ch),
      .i_wr_arm     (wr_arm),
      .i_wr_mode    (wr_mode),
      .i_wr_time    (wr_time),
      .i_wr_period  (wr_period),
      .i_ack        (ack),
      .i_ack_ch     (ack_ch),
      .o_int        (o_int),
      .o_int_ch     (o_int_ch),
      .o_pending    (o_pending),
      .o_armed      (o_armed),
      .o_overrun    (o_overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr_en;
      logic [1:0]    wr_ch;
      logic          arm;
      logic          mode;
      logic [TW-1:0] tm;
      logic [TW-1:0] per;
      logic          ack;
      logic [1:0]    ack_ch;
      logic [TW-1:0] ct;
      logic          e_int;
      logic [1:0]    e_ch;
      logic [3:0]    e_pend;
      logic [3:0]    e_arm;
      logic [3:0]    e_ovr;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] wc, input logic a, input logic m,
                               input int tm, input int per, input logic ak, input logic [1:0] ac,
                               input int ct, input logic ei, input logic [1:0] ec,
                               input logic [3:0] p, input logic [3:0] ar, input logic [3:0] ov);
      vec_t v;
      v.wr_en = we; v.wr_ch = wc; v.arm = a; v.mode = m;
      v.tm = TW'(tm); v.per = TW'(per); v.ack = ak; v.ack_ch = ac; v.ct = TW'(ct);
      v.e_int = ei; v.e_ch = ec; v.e_pend = p; v.e_arm = ar; v.e_ovr = ov;
      return v;
   endfunction

   task automatic add_idle(input int ct, input logic ei, input logic [1:0] ec,
                           input logic [3:0] p, input logic [3:0] ar, input logic [3:0] ov);
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ct, ei, ec, p, ar, ov));
   endtask

   task automatic add_wr(input logic [1:0] ch, input logic a, input logic m, input int tm,
                         input int per, input int ct, input logic ei, input logic [1:0] ec,
                         input logic [3:0] p, input logic [3:0] ar, input logic [3:0] ov);
      tbl.push_back(mk(1, ch, a, m, tm, per, 0, 0, ct, ei, ec, p, ar, ov));
   endtask

   task automatic add_ack(input logic [1:0] ch, input int ct, input logic ei, input logic [1:0] ec,
                          input logic [3:0] p, input logic [3:0] ar, input logic [3:0] ov);
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, ch, ct, ei, ec, p, ar, ov));
   endtask

   task automatic idle_inputs();
      wr_en = 0; wr_ch = 0; wr_arm = 0; wr_mode = 0; wr_time = 0; wr_period = 0;
      ack = 0; ack_ch = 0;
   endtask

   task automatic check_outs(input string tag, input logic ei, input logic [1:0] ec,
                             input logic [3:0] p, input logic [3:0] ar, input logic [3:0] ov);
      check({tag, " int"},     32'(o_int),     32'(ei));
      check({tag, " int_ch"},  32'(o_int_ch),  32'(ec));
      check({tag, " pending"}, 32'(o_pending), 32'(p));
      check({tag, " armed"},   32'(o_armed),   32'(ar));
      check({tag, " overrun"}, 32'(o_overrun), 32'(ov));
   endtask

   // Reference model: per-channel state updated from the behavioural rules.
   logic [TW-1:0] m_time [NC];
   logic [TW-1:0] m_per  [NC];
   logic          m_mode [NC];
   logic          m_arm  [NC];
   logic          m_pend [NC];
   logic          m_ovr  [NC];

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         m_time[c] = 0; m_per[c] = 0; m_mode[c] = 0;
         m_arm[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
      end
   endtask

   task automatic model_step();
      for (int c = 0; c < NC; c++) begin
         bit w, a, hit;
         w   = wr_en && (int'(wr_ch) == c);
         a   = ack && (int'(ack_ch) == c);
         hit = m_arm[c] && (m_time[c] == clk_time);
         if (w) begin
            m_arm[c] = wr_arm; m_pend[c] = 0; m_ovr[c] = 0;
            if (wr_arm) begin
               m_time[c] = wr_time; m_per[c] = wr_period; m_mode[c] = wr_mode;
            end
         end else if (hit) begin
            if (m_mode[c] && m_per[c] != 0) begin
               if (m_pend[c] && !a) m_ovr[c] = 1;
               m_time[c] = TW'((int'(m_time[c]) + int'(m_per[c])) % 256);
            end else begin
               m_arm[c] = 0;
            end
            m_pend[c] = 1;
         end else if (a) begin
            m_pend[c] = 0;
         end
      end
   endtask

   initial begin
      logic [3:0] ep, ea, eo;
      logic [1:0] ec;
      logic       found;
      int         r;

      idle_inputs();
      clk_time = 0;
      i_arst   = 1;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 0, 0, 0, 0, 0);
      i_arst = 0;

      // ch0 one-shot at 100, clock ramps through it
      add_wr(0, 1, 0, 100, 0, 95, 0, 0, 4'h0, 4'h1, 4'h0);
      for (int c = 96; c <= 99; c++) add_idle(c, 0, 0, 4'h0, 4'h1, 4'h0);
      add_idle(100, 1, 0, 4'h1, 4'h0, 4'h0);
      add_idle(101, 1, 0, 4'h1, 4'h0, 4'h0);
      add_ack(0, 102, 0, 0, 4'h0, 4'h0, 4'h0);
      add_idle(103, 0, 0, 4'h0, 4'h0, 4'h0);
      // ch1 periodic 10/+5, stalled clock gives one event, then overrun
      add_wr(1, 1, 1, 10, 5, 0, 0, 0, 4'h0, 4'h2, 4'h0);
      for (int k = 0; k < 4; k++) add_idle(10, 1, 1, 4'h2, 4'h2, 4'h0);
      for (int c = 11; c <= 14; c++) add_idle(c, 1, 1, 4'h2, 4'h2, 4'h0);
      add_idle(15, 1, 1, 4'h2, 4'h2, 4'h2);
      add_ack(1, 16, 0, 0, 4'h0, 4'h2, 4'h2);
      add_idle(20, 1, 1, 4'h2, 4'h2, 4'h2);
      add_ack(1, 21, 0, 0, 4'h0, 4'h2, 4'h2);
      // wrap-around 250/+10 -> 4 -> 14, then disarm
      add_wr(1, 1, 1, 250, 10, 0, 0, 0, 4'h0, 4'h2, 4'h0);
      add_idle(250, 1, 1, 4'h2, 4'h2, 4'h0);
      add_ack(1, 251, 0, 0, 4'h0, 4'h2, 4'h0);
      add_idle(4, 1, 1, 4'h2, 4'h2, 4'h0);
      add_ack(1, 5, 0, 0, 4'h0, 4'h2, 4'h0);
      add_idle(14, 1, 1, 4'h2, 4'h2, 4'h0);
      add_wr(1, 0, 0, 0, 0, 15, 0, 0, 4'h0, 4'h0, 4'h0);
      // ch2 and ch3 fire together, priority to lowest index
      add_wr(2, 1, 0, 50, 0, 0, 0, 0, 4'h0, 4'h4, 4'h0);
      add_wr(3, 1, 0, 50, 0, 0, 0, 0, 4'h0, 4'hC, 4'h0);
      add_idle(50, 1, 2, 4'hC, 4'h0, 4'h0);
      add_ack(2, 51, 1, 3, 4'h8, 4'h0, 4'h0);
      add_ack(3, 52, 0, 0, 4'h0, 4'h0, 4'h0);
      // write beats match; match beats ack
      add_wr(0, 1, 0, 60, 0, 0, 0, 0, 4'h0, 4'h1, 4'h0);
      add_wr(0, 1, 1, 70, 3, 60, 0, 0, 4'h0, 4'h1, 4'h0);
      add_idle(61, 0, 0, 4'h0, 4'h1, 4'h0);
      add_idle(70, 1, 0, 4'h1, 4'h1, 4'h0);
      add_ack(0, 73, 1, 0, 4'h1, 4'h1, 4'h0);
      add_ack(0, 74, 0, 0, 4'h0, 4'h1, 4'h0);
      add_wr(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);

      foreach (tbl[i]) begin
         wr_en = tbl[i].wr_en; wr_ch = tbl[i].wr_ch; wr_arm = tbl[i].arm;
         wr_mode = tbl[i].mode; wr_time = tbl[i].tm; wr_period = tbl[i].per;
         ack = tbl[i].ack; ack_ch = tbl[i].ack_ch; clk_time = tbl[i].ct;
         @(posedge clk);
         #1;
         check_outs($sformatf("row%0d", i), tbl[i].e_int, tbl[i].e_ch,
                    tbl[i].e_pend, tbl[i].e_arm, tbl[i].e_ovr);
      end
      idle_inputs();

      // Asynchronous reset while ch1 pending and ch0 armed
      wr_en = 1; wr_ch = 0; wr_arm = 1; wr_mode = 0; wr_time = 200; clk_time = 0;
      @(posedge clk); #1;
      wr_ch = 1; wr_time = 20;
      @(posedge clk); #1;
      idle_inputs();
      clk_time = 20;
      @(posedge clk); #1;
      check_outs("pre-reset", 1, 1, 4'h2, 4'h1, 4'h0);
      #2 i_arst = 1;
      #1;
      check_outs("async reset", 0, 0, 4'h0, 4'h0, 4'h0);
      @(posedge clk); #1;
      i_arst = 0;
      for (int c = 195; c <= 205; c++) begin
         clk_time = TW'(c);
         @(posedge clk); #1;
         check($sformatf("post-reset int t=%0d", c), 32'({o_int, o_armed}), 32'(0));
      end

      // Randomized traffic against the model
      i_arst = 1;
      @(posedge clk); #1;
      i_arst = 0;
      model_reset();
      clk_time = 0;
      for (int n = 0; n < 3000; n++) begin
         wr_en     = ($urandom_range(0, 7) == 0);
         wr_ch     = 2'($urandom_range(0, 3));
         wr_arm    = ($urandom_range(0, 3) != 0);
         wr_mode   = 1'($urandom_range(0, 1));
         wr_time   = TW'(int'(clk_time) + int'($urandom_range(0, 20)));
         wr_period = ($urandom_range(0, 7) == 0) ? TW'(0) : TW'($urandom_range(1, 12));
         ack       = ($urandom_range(0, 3) == 0);
         ack_ch    = 2'($urandom_range(0, 3));
         @(posedge clk);
         model_step();
         #1;
         ep = '0; ea = '0; eo = '0; ec = '0; found = 0;
         for (int c = 0; c < NC; c++) begin
            ep[c] = m_pend[c]; ea[c] = m_arm[c]; eo[c] = m_ovr[c];
            if (m_pend[c] && !found) begin
               ec = 2'(c); found = 1;
            end
         end
         check($sformatf("rand%0d {int,ch,pend,arm,ovr}", n),
               32'({o_int, o_int_ch, o_pending, o_armed, o_overrun}),
               32'({|ep, ec, ep, ea, eo}));
         r = $urandom_range(0, 9);
         if (r < 6)      clk_time = clk_time + 1'b1;
         else if (r < 8) clk_time = clk_time;
         else            clk_time = TW'($urandom_range(0, 255));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
